// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback queue in front of the register file's single write port.
// Accepts results from the ALU and memory-load producers, keeps them in order in a small
// FIFO, and drains one entry per cycle onto RegWrite/WriteReg/WriteData. It also offers
// a combinational forwarding lookup so decode can see values that are queued but not yet
// committed to the register file.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_reg/alu_data       ALU writeback request
//   mem_valid/mem_reg/mem_data       load writeback request (older when both arrive together)
//   in_ready                         both producers may present a request this cycle
//   rs, rt                           forwarding lookup addresses
//   fwd1_hit/fwd1_data               youngest pending write matching rs (data 0 on miss)
//   fwd2_hit/fwd2_data               youngest pending write matching rt (data 0 on miss)
//   RegWrite/WriteReg/WriteData      registered register-file write port
//   count                            FIFO occupancy
module rf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  localparam int unsigned CW   = $clog2(DEPTH) + 1,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  output logic          in_ready,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          fwd1_hit,
  output logic [DW-1:0] fwd1_data,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd2_data,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic [CW-1:0] count
);

  logic [AW-1:0] regs_q [DEPTH];
  logic [AW-1:0] regs_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic          mem_push, alu_push, pop;
  logic [PW-1:0] alu_idx;
  logic [PW-1:0] fwd_idx;

  // Two free slots are required so both producers can always be accepted together;
  // the same-cycle pop is deliberately ignored.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  // Writes to register 0 complete the handshake but are discarded.
  assign mem_push = mem_valid && in_ready && (mem_reg != '0);
  assign alu_push = alu_valid && in_ready && (alu_reg != '0);
  assign pop      = (count_q != '0);

  // The ALU entry lands behind the mem entry when both are pushed together.
  assign alu_idx  = wr_ptr_q + PW'(mem_push);

  always_comb begin
    regs_d = regs_q;
    data_d = data_q;
    if (mem_push) begin
      regs_d[wr_ptr_q] = mem_reg;
      data_d[wr_ptr_q] = mem_data;
    end
    if (alu_push) begin
      regs_d[alu_idx] = alu_reg;
      data_d[alu_idx] = alu_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = regs_q[rd_ptr_q];
      write_data_d = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      regs_q       <= regs_d;
      data_q       <= data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Forwarding: the output stage is checked first (oldest), then FIFO entries from head to
  // tail so that later, younger matches overwrite earlier ones.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fwd_idx   = '0;
    if (reg_write_q) begin
      if ((rs != '0) && (write_reg_q == rs)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = write_data_q;
      end
      if ((rt != '0) && (write_reg_q == rt)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = write_data_q;
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((rs != '0) && (regs_q[fwd_idx] == rs)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[fwd_idx];
        end
        if ((rt != '0) && (regs_q[fwd_idx] == rt)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[fwd_idx];
        end
      end
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign count     = count_q;

endmodule
